// File: rtl/rx_lane_deskew_ctrl.sv
// Lane-deskew master controller: common read start, AM agreement FSM,
// common buffer reset generation and sticky status for software.
module rx_lane_deskew_ctrl #(
  parameter int LNUM     = 4,
  parameter int CW       = 8,
  parameter int RST_HOLD = 15,
  parameter int TMO_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [LNUM-1:0]  i_lden,
  input  logic [LNUM-1:0]  i_wr_half_full,
  input  logic [LNUM-1:0]  i_am_locked,
  input  logic [LNUM-1:0]  i_is_am,
  input  logic [LNUM-1:0]  i_flow,
  input  logic [CW-1:0]    i_align_det_thres,
  input  logic [CW-1:0]    i_align_los_thres,
  input  logic [TMO_W-1:0] i_acq_timeout,
  input  logic             i_err_clr,
  output logic             o_rd_en,
  output logic             o_rst_all_n,
  output logic             o_align_acqr,
  output logic             o_am_match_err,
  output logic [1:0]       o_fsm,
  output logic [LNUM-1:0]  o_err_lanes,
  output logic [4:0]       o_rst_cause,
  output logic [CW-1:0]    o_loa_cnt
);

  typedef enum logic [1:0] {
    S_LOSS = 2'd0,
    S_DET  = 2'd1,
    S_ACQ  = 2'd2,
    S_VER  = 2'd3
  } state_t;

  localparam int HW = $clog2(RST_HOLD + 1);

  state_t            r_fsm;
  state_t            w_fsm_nxt;
  logic [CW-1:0]     r_det_cnt;
  logic [CW-1:0]     w_det_nxt;
  logic [CW-1:0]     r_los_cnt;
  logic [CW-1:0]     w_los_nxt;
  logic              r_rd_en;
  logic              r_rst_all_n;
  logic              r_acqr;
  logic              r_fsm_req;
  logic              w_fsm_req;
  logic              r_tmo_req;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [HW-1:0]     r_hold_cnt;
  logic [LNUM-1:0]   r_lden_q;
  logic [LNUM-1:0]   r_err_lanes;
  logic [4:0]        r_rst_cause;
  logic [CW-1:0]     r_loa_cnt;

  logic              w_all;
  logic              w_none;
  logic              w_err;
  logic              w_hold_act;
  logic              w_flow_hit;
  logic              w_src_flow;
  logic              w_src_lock;
  logic              w_src_lden;
  logic [4:0]        w_src;
  logic              w_dom_rst;
  logic              w_rd_set;
  logic              w_acq_nxt;
  logic              w_tmo_run;
  logic              w_tmo_hit;
  logic              w_loa_inc;
  logic [CW-1:0]     w_loa_base;

  assign w_all  = r_rd_en & (&(i_is_am | ~i_lden));
  assign w_none = r_rd_en & ~(|(i_is_am & i_lden));
  assign w_err  = r_rd_en & ~(w_all | w_none);

  // Flow is ignored while a hold is running; it is re-sampled once idle.
  assign w_hold_act = (r_hold_cnt != '0);
  assign w_flow_hit = ~w_hold_act & (|(i_flow & i_lden));
  assign w_src_flow = w_hold_act | w_flow_hit;
  assign w_src_lock = |(~i_am_locked & i_lden);
  assign w_src_lden = (i_lden != r_lden_q);

  assign w_src = {r_tmo_req, w_src_lden, r_fsm_req,
                  w_src_lock, w_src_flow};

  assign w_dom_rst = i_rst | ~r_rst_all_n;
  assign w_rd_set  = (|i_lden) & (&(i_wr_half_full | ~i_lden));

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_det_nxt = '0;
    w_los_nxt = '0;
    w_fsm_req = 1'b0;
    unique case (r_fsm)
      S_LOSS: begin
        if (w_all) w_fsm_nxt = S_DET;
        else if (w_err) w_fsm_req = 1'b1;
      end
      S_DET: begin
        if (w_err) begin
          w_fsm_nxt = S_LOSS;
        end else if (w_all) begin
          if (r_det_cnt == i_align_det_thres) w_fsm_nxt = S_ACQ;
          else w_det_nxt = r_det_cnt + CW'(1);
        end else begin
          w_det_nxt = r_det_cnt;
        end
      end
      S_ACQ: begin
        if (w_err) w_fsm_nxt = S_VER;
      end
      S_VER: begin
        if (w_all && r_los_cnt == '0) w_fsm_nxt = S_ACQ;
        else if (w_err && r_los_cnt == i_align_los_thres)
          w_fsm_nxt = S_LOSS;
        else if (w_err) w_los_nxt = r_los_cnt + CW'(1);
        else if (w_all) w_los_nxt = r_los_cnt - CW'(1);
        else w_los_nxt = r_los_cnt;
      end
      default: w_fsm_nxt = S_LOSS;
    endcase
    if (w_dom_rst) begin
      w_fsm_nxt = S_LOSS;
      w_det_nxt = '0;
      w_los_nxt = '0;
      w_fsm_req = 1'b0;
    end
  end

  assign w_acq_nxt = (w_fsm_nxt == S_ACQ) | (w_fsm_nxt == S_VER);

  assign w_tmo_run = r_rd_en & (i_acq_timeout != '0) &
                     ((r_fsm == S_LOSS) | (r_fsm == S_DET));
  assign w_tmo_hit = w_tmo_run & (r_tmo_cnt == i_acq_timeout);

  always_ff @(posedge i_clk) begin
    r_fsm       <= w_fsm_nxt;
    r_det_cnt   <= w_det_nxt;
    r_los_cnt   <= w_los_nxt;
    r_fsm_req   <= w_fsm_req;
    r_acqr      <= w_acq_nxt;
    r_rd_en     <= ~w_dom_rst & (r_rd_en | w_rd_set);
    r_rst_all_n <= ~i_rst & ~(|w_src);
  end

  always_ff @(posedge i_clk) begin
    if (w_dom_rst) begin
      r_tmo_cnt <= '0;
      r_tmo_req <= 1'b0;
    end else begin
      r_tmo_req <= w_tmo_hit;
      if (w_tmo_hit || w_fsm_nxt == S_ACQ) r_tmo_cnt <= '0;
      else if (w_tmo_run) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_hold_cnt <= '0;
    else if (w_flow_hit) r_hold_cnt <= HW'(RST_HOLD - 1);
    else if (w_hold_act) r_hold_cnt <= r_hold_cnt - HW'(1);
  end

  // A clear and a new event in the same cycle keeps the new event.
  assign w_loa_inc  = r_acqr & ~w_acq_nxt;
  assign w_loa_base = i_err_clr ? '0 : r_loa_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lden_q    <= '0;
      r_err_lanes <= '0;
      r_rst_cause <= '0;
      r_loa_cnt   <= '0;
    end else begin
      r_lden_q    <= i_lden;
      r_rst_cause <= (i_err_clr ? 5'd0 : r_rst_cause) | w_src;
      r_err_lanes <= (i_err_clr ? '0 : r_err_lanes) |
                     (w_err ? (i_lden & ~i_is_am) : '0);
      if (w_loa_inc && w_loa_base != '1)
        r_loa_cnt <= w_loa_base + CW'(1);
      else
        r_loa_cnt <= w_loa_base;
    end
  end

  assign o_rd_en        = r_rd_en;
  assign o_rst_all_n    = r_rst_all_n;
  assign o_align_acqr   = r_acqr;
  assign o_am_match_err = w_err & ~i_rst;
  assign o_fsm          = r_fsm;
  assign o_err_lanes    = r_err_lanes;
  assign o_rst_cause    = r_rst_cause;
  assign o_loa_cnt      = r_loa_cnt;

endmodule

// File: doc/rx_lane_deskew_ctrl.md
# rx_lane_deskew_ctrl

Parametrised lane-deskew master controller for the MII/Ethernet RX path. It sits above the per-lane deskew buffers.
- Starts a common read once every enabled lane buffer is half full.
- Monitors alignment-marker agreement through the PCS deskew state machine.
- Issues a common buffer reset on overflow, lock loss, lane-enable change, FSM mismatch or acquisition timeout.
- Keeps sticky per-lane error and reset-cause status plus a loss-of-alignment event counter for software.

## Interface
- LNUM, 4: number of lanes (1..16)
- CW, 8: width of thresholds and loss-of-alignment counter
- RST_HOLD, 15: cycles the buffer reset is held after an overflow (must be >= 10)
- TMO_W, 16: width of acquisition-timeout counter
- i_clk  in  1  single clock for the block
- i_rst  in  1  synchronous reset, active-high
- i_lden  in  LNUM  lane deskew enable; disabled lanes always count as matching
- i_wr_half_full  in  LNUM  lane buffer has reached half full
- i_am_locked  in  LNUM  lane alignment-marker lock
- i_is_am  in  LNUM  current read word of the lane is a marker
- i_flow  in  LNUM  lane buffer over/underflow
- i_align_det_thres  in  CW  detect threshold
- i_align_los_thres  in  CW  loss threshold
- i_acq_timeout  in  TMO_W  acquisition timeout in cycles; 0 disables the timeout
- i_err_clr  in  1  clears sticky status and the event counter
- o_rd_en  out  1  common read enable to all lanes
- o_rst_all_n  out  1  deskew-buffer reset, active-low, registered
- o_align_acqr  out  1  alignment acquired (state ACQUIRED or VERIFY)
- o_am_match_err  out  1  combinational: some enabled lanes read a marker and some do not
- o_fsm  out  2  state: 0 LOSS, 1 DETECT, 2 ACQUIRED, 3 VERIFY
- o_err_lanes  out  LNUM  sticky: lanes that missed a marker during a mismatch
- o_rst_cause  out  5  sticky, bit order [4:0] = {timeout, lden, fsm, lock, flow}
- o_loa_cnt  out  CW  saturating count of o_align_acqr 1->0 events

## Operation
- Reset sources, all evaluated at edge t; o_rst_all_n(t+1) = ~i_rst & ~any source:
  - **flow**: a flow hold is active.
  - **lock**: some enabled lane has i_am_locked=0.
  - **lden**: i_lden differs from its registered copy. The registered copy resets to 0.
  - **fsm**: the one-cycle FSM reset request is high.
  - **timeout**: the one-cycle timeout request is high.
- Flow hold:
  - While idle, (i_flow & i_lden) != 0 starts the hold, lasting exactly RST_HOLD cycles starting next cycle.
  - i_flow is ignored during the hold and re-sampled when it ends. A persistent flow therefore re-arms the hold immediately.
- Domain reset: FSM, det/los counters, o_rd_en, o_align_acqr and the timeout counter are cleared when i_rst is high or o_rst_all_n is low.
- Sticky status and o_loa_cnt are cleared only by i_rst or i_err_clr. On a same-cycle clear and set, set wins.
- o_rd_en:
  - Sets when every enabled lane has i_wr_half_full=1 and at least one lane is enabled.
  - Once set, it stays high until a domain reset.
  - With i_lden=0, o_rd_en stays 0 and the FSM stays in LOSS.
- Match terms, all gated by o_rd_en:
  - all = &(i_is_am | ~i_lden)
  - none = ~|(i_is_am & i_lden)
  - err = ~(all | none)
- FSM transitions:
  - **LOSS**: all -> DETECT. err -> stay in LOSS and raise the FSM reset request next cycle.
  - **DETECT**: all and det_cnt == det_thres -> ACQUIRED. err -> LOSS. det_cnt increments on all and is 0 outside DETECT. Acquisition takes det_thres+2 consecutive all-match markers.
  - **ACQUIRED**: err -> VERIFY.
  - **VERIFY**:
    - all and los_cnt == 0 -> ACQUIRED.
    - err and los_cnt == los_thres -> LOSS.
    - Otherwise, los_cnt increments on err and decrements on all. los_cnt is 0 outside VERIFY.
  - Counters are CW bits and wrap. Thresholds are compared for equality only.
- Timeout:
  - The counter runs while o_rd_en=1, the state is LOSS or DETECT, and i_acq_timeout != 0.
  - When it equals i_acq_timeout, a one-cycle request is raised and the counter clears.
  - The counter clears on entering ACQUIRED or on domain reset.
- o_err_lanes |= (i_lden & ~i_is_am) on every err cycle. o_rst_cause bits set in the cycle their source is active.
- o_loa_cnt increments when o_align_acqr falls for any reason, including domain reset. It saturates at all ones.

## Timing
- Values while i_rst is high: o_rst_all_n=0, o_rd_en=0, o_align_acqr=0, o_am_match_err=0, o_fsm=0, o_err_lanes=0, o_rst_cause=0, o_loa_cnt=0.
- Flow high at edge t: o_rst_all_n is low from t+1 through t+RST_HOLD and rises at t+RST_HOLD+1 if no other source is active.
- FSM reset: an err in LOSS at edge t gives a request at t+1 and o_rst_all_n low at t+2. That reset clears the request, so the pulse is exactly one cycle.
- o_rd_en rises one edge after the half-full condition is met with o_rst_all_n=1.
- o_align_acqr is registered from the next state, so it changes on the same edge as o_fsm.
- A lane-enable change costs exactly one reset cycle.
- i_rst deasserted at edge t with i_lden=0 and no flow: o_rst_all_n=1 at t+1.

## Test plan
- LNUM=4, lden=4'hF, all locked, half-full on cycle 5, det_thres=2 -> o_rd_en=1 on cycle 6; 4 consecutive all-match markers -> o_fsm=2, o_align_acqr=1.
- Lane 2 flow for 1 cycle with RST_HOLD=15 -> o_rst_all_n low for exactly 15 cycles; o_rst_cause=5'b00001; o_rd_en=0, then re-arms.
- In ACQUIRED with los_thres=1, is_am=4'b1011 three times -> o_fsm=3, then 3, then 0; o_err_lanes=4'b0100; o_loa_cnt=1.
- In LOSS, is_am=4'b0011 -> one-cycle o_rst_all_n low 2 edges later; o_rst_cause[2]=1.
- acq_timeout=100 with no markers -> o_rst_all_n pulses low 100 cycles after o_rd_en rises, and again periodically; with acq_timeout=0, no pulse.
- Toggle i_lden to 4'h7 while acquired -> one reset cycle, lane 3 ignored afterwards; o_loa_cnt increments; i_err_clr zeroes all sticky outputs.
